// File: rtl/route_distance.sv
// route_distance: captures one route of city indices and sums its closed-tour length
// through an external 1-cycle-latency distance table. Optional check: ROUTE_DISTANCE_CHECK_EN.
module route_distance #(
   parameter int city_num     = 16,
   parameter int city_num_log = 4,
   parameter int city_div_log = 1,
   parameter int dist_bit     = 8,
   parameter int total_bit    = dist_bit + city_num_log
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic                      in_valid,
   input  logic [8*city_num_log-1:0] in_data,
   output logic [2*city_num_log-1:0] dist_raddr,
   output logic                      dist_ren,
   input  logic [dist_bit-1:0]       dist_rdata,
   output logic                      busy,
   output logic                      done,
   output logic [total_bit-1:0]      total,
   output logic                      overrun,
   output logic                      perm_error
);

   localparam int word_w   = 8 * city_num_log;
   localparam int depth    = 2 ** city_div_log;
   localparam int city_div = (city_num + 7) / 8;

   localparam logic [city_div_log-1:0] last_word = city_div_log'(city_div - 1);
   localparam logic [city_num_log-1:0] last_city = city_num_log'(city_num - 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_LOAD  = 3'd1;
   localparam logic [2:0] S_WALK  = 3'd2;
   localparam logic [2:0] S_DRAIN = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [2:0]              state_q, state_d;
   logic [city_div_log-1:0] wcount_q, wcount_d;
   logic [city_num_log-1:0] k_q, k_d;
   logic [word_w-1:0]       words_q [depth];
   logic [word_w-1:0]       words_d [depth];
   logic                    rd_pend_q, rd_pend_d;
   logic [total_bit-1:0]    total_q, total_d;
   logic                    overrun_q, overrun_d;

   logic                    accept;
   logic [city_div_log-1:0] word_idx;
   logic [city_num_log-1:0] k_next;
   logic [depth*word_w-1:0] tour;

   // A word is taken in LOAD, or as word 0 in the same cycle as start.
   assign accept   = in_valid && (start || (state_q == S_LOAD));
   assign word_idx = start ? '0 : wcount_q;
   assign k_next   = (k_q == last_city) ? '0 : k_q + city_num_log'(1);

   assign dist_ren = (state_q == S_WALK);
   assign busy     = (state_q == S_LOAD) || (state_q == S_WALK) || (state_q == S_DRAIN);
   assign done     = (state_q == S_DONE);
   assign total    = total_q;
   assign overrun  = overrun_q;

   // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
   always_comb begin
      tour       = '0;
      dist_raddr = '0;
      for (int w = 0; w < depth; w++) begin
         tour[w*word_w +: word_w] = words_q[w];
      end
      if (state_q == S_WALK) begin
         dist_raddr = {tour[int'(k_q)*city_num_log +: city_num_log],
                       tour[int'(k_next)*city_num_log +: city_num_log]};
      end
   end

   // NOTE: next-state logic uses blocking '=' so later lines (start, accept) override earlier ones.
   always_comb begin
      state_d   = state_q;
      wcount_d  = wcount_q;
      k_d       = k_q;
      words_d   = words_q;
      rd_pend_d = dist_ren;
      total_d   = total_q;
      overrun_d = overrun_q;

      if (rd_pend_q) begin
         total_d = total_q + total_bit'(dist_rdata);
      end

      case (state_q)
         S_WALK: begin
            k_d = k_next;
            if (k_q == last_city) begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = state_q;
      endcase

      if (in_valid && ((state_q == S_WALK) || (state_q == S_DRAIN) || (state_q == S_DONE))) begin
         overrun_d = 1'b1;
      end

      // start aborts whatever is in flight, including a read still returning.
      if (start) begin
         state_d   = S_LOAD;
         wcount_d  = '0;
         k_d       = '0;
         rd_pend_d = 1'b0;
         total_d   = '0;
         overrun_d = 1'b0;
         for (int w = 0; w < depth; w++) begin
            words_d[w] = '0;
         end
      end

      if (accept) begin
         words_d[word_idx] = in_data;
         if (word_idx == last_word) begin
            state_d = S_WALK;
         end else begin
            wcount_d = word_idx + city_div_log'(1);
         end
      end
   end

   // NOTE: sequential state uses non-blocking '<=' so all registers update from pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         wcount_q  <= '0;
         k_q       <= '0;
         words_q   <= '{default: '0};
         rd_pend_q <= 1'b0;
         total_q   <= '0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wcount_q  <= wcount_d;
         k_q       <= k_d;
         words_q   <= words_d;
         rd_pend_q <= rd_pend_d;
         total_q   <= total_d;
         overrun_q <= overrun_d;
      end
   end

`ifdef ROUTE_DISTANCE_CHECK_EN
   logic [city_num-1:0]     seen_q, seen_d;
   logic                    perm_err_q, perm_err_d;
   logic [city_num_log-1:0] chk_city;

   // Cities of one word are checked in order, so duplicates inside a word are caught too.
   always_comb begin
      seen_d     = start ? '0 : seen_q;
      perm_err_d = start ? 1'b0 : perm_err_q;
      chk_city   = '0;
      if (accept) begin
         for (int i = 0; i < 8; i++) begin
            chk_city = in_data[i*city_num_log +: city_num_log];
            if (int'(word_idx) * 8 + i < city_num) begin
               if ({1'b0, chk_city} >= (city_num_log + 1)'(city_num)) begin
                  perm_err_d = 1'b1;
               end else begin
                  if (seen_d[chk_city]) begin
                     perm_err_d = 1'b1;
                  end
                  seen_d[chk_city] = 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         seen_q     <= '0;
         perm_err_q <= 1'b0;
      end else begin
         seen_q     <= seen_d;
         perm_err_q <= perm_err_d;
      end
   end

   assign perm_error = perm_err_q;
`else
   assign perm_error = 1'b0;
`endif

endmodule

// File: tb/tb_route_distance.sv
// Self-checking bench for route_distance: random and directed routes against a
// tour-length model, with a |from-to| distance table answering one cycle late.
module tb_route_distance;

   localparam int N = 16;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] in_data = '0;
   logic [7:0]  dist_raddr;
   logic        dist_ren;
   logic [7:0]  dist_rdata = '0;
   logic        busy, done;
   logic [11:0] total;
   logic        overrun, perm_error;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int route_c[N];

   int   ren_cnt, first_ren, last_ren, done_cnt, done_cyc, addr_bad, done_total;
   logic done_ovr, done_perm;

   route_distance dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .dist_raddr (dist_raddr),
      .dist_ren   (dist_ren),
      .dist_rdata (dist_rdata),
      .busy       (busy),
      .done       (done),
      .total      (total),
      .overrun    (overrun),
      .perm_error (perm_error)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   function automatic int absdiff(input int a, input int b);
      return (a > b) ? a - b : b - a;
   endfunction

   function automatic int tour_len();
      int s = 0;
      for (int k = 0; k < N; k++) s += absdiff(route_c[k], route_c[(k + 1) % N]);
      return s;
   endfunction

   // Distance table: answers the next cycle; garbage when no read was issued.
   always @(posedge clk) begin
      if (dist_ren) dist_rdata <= 8'(absdiff(int'(dist_raddr[7:4]), int'(dist_raddr[3:0])));
      else          dist_rdata <= 8'($urandom);
   end

   // Cycle numbers name a cycle by the edge that closes it.
   always @(negedge clk) begin
      if (!reset) begin
         if (dist_ren) begin
            if (ren_cnt == 0) first_ren = cyc + 1;
            last_ren = cyc + 1;
            if (ren_cnt < N &&
                dist_raddr !== {4'(route_c[ren_cnt]), 4'(route_c[(ren_cnt + 1) % N])})
               addr_bad++;
            ren_cnt++;
         end
         if (done) begin
            done_cnt++;
            done_cyc   = cyc + 1;
            done_total = int'(total);
            done_ovr   = overrun;
            done_perm  = perm_error;
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   task automatic clear_mon();
      ren_cnt = 0; first_ren = -1; last_ren = -1; done_cnt = 0; done_cyc = -1;
      addr_bad = 0; done_total = -1; done_ovr = 1'bx; done_perm = 1'bx;
   endtask

   task automatic shuffle_route();
      for (int i = 0; i < N; i++) route_c[i] = i;
      for (int i = N - 1; i > 0; i--) begin
         int j = $urandom_range(0, i);
         int tmp = route_c[i];
         route_c[i] = route_c[j];
         route_c[j] = tmp;
      end
   endtask

   // Start a route and feed both words; t is the edge that accepts the last word.
   task automatic do_route(input int gap, input bit combined, output int t);
      logic [31:0] w0, w1;
      for (int i = 0; i < 8; i++) begin
         w0[i*4 +: 4] = 4'(route_c[i]);
         w1[i*4 +: 4] = 4'(route_c[8 + i]);
      end
      @(posedge clk); #1;
      start = 1'b1;
      if (combined) begin in_valid = 1'b1; in_data = w0; end
      @(posedge clk); #1;
      start = 1'b0; in_valid = 1'b0;
      clear_mon();
      if (!combined) begin
         in_valid = 1'b1; in_data = w0;
         @(posedge clk); #1;
         in_valid = 1'b0;
      end
      repeat (gap) begin @(posedge clk); #1; end
      in_valid = 1'b1; in_data = w1; t = cyc + 1;
      @(posedge clk); #1;
      in_valid = 1'b0; in_data = '0;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 60 && done_cnt == 0; i++) @(posedge clk);
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if ({busy, done, dist_ren, dist_raddr, total, overrun, perm_error} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got busy=%b done=%b ren=%b raddr=%h total=%0d ovr=%b perm=%b expected all 0",
                  busy, done, dist_ren, dist_raddr, total, overrun, perm_error);
      end
      reset = 1'b0;
      in_valid = 1'b1; in_data = 32'hdead_beef;
      repeat (2) begin @(posedge clk); #1; end
      in_valid = 1'b0;
      n_checks++;
      if ({busy, overrun, dist_ren} !== 3'b000) begin
         n_fail++;
         $display("FAIL idle_drop: got busy=%b overrun=%b ren=%b expected 0 0 0", busy, overrun, dist_ren);
      end
   endtask

   task automatic test_identity();
      int t, exp;
      for (int i = 0; i < N; i++) route_c[i] = i;
      exp = tour_len();
      do_route(0, 1'b0, t);
      wait_done();
      n_checks++;
      if (done_cnt !== 1) begin n_fail++; $display("FAIL ident_done_count: got %0d expected 1", done_cnt); end
      n_checks++;
      if (ren_cnt !== N) begin n_fail++; $display("FAIL ident_ren_count: got %0d expected %0d", ren_cnt, N); end
      n_checks++;
      if (first_ren !== t + 1 || last_ren !== t + N) begin
         n_fail++;
         $display("FAIL ident_ren_window: got %0d..%0d expected %0d..%0d", first_ren, last_ren, t + 1, t + N);
      end
      n_checks++;
      if (done_cyc !== t + N + 2) begin n_fail++; $display("FAIL ident_done_cycle: got %0d expected %0d", done_cyc, t + N + 2); end
      n_checks++;
      if (done_total !== exp) begin n_fail++; $display("FAIL ident_total: got %0d expected %0d", done_total, exp); end
      n_checks++;
      if (addr_bad !== 0) begin n_fail++; $display("FAIL ident_raddr: got %0d bad reads expected 0", addr_bad); end
      n_checks++;
      if (int'(total) !== exp || busy !== 1'b0 || done_ovr !== 1'b0) begin
         n_fail++;
         $display("FAIL ident_hold: got total=%0d busy=%b ovr=%b expected %0d 0 0", total, busy, done_ovr, exp);
      end
   endtask

   task automatic test_patterns();
      int t;
      for (int p = 0; p < 2; p++) begin
         for (int i = 0; i < N; i++)
            route_c[i] = (p == 0) ? (N - 1 - i) : ((i < 8) ? 2 * i : 2 * (N - 1 - i) + 1);
         do_route(0, 1'b0, t);
         wait_done();
         n_checks++;
         if (done_total !== tour_len() || done_ovr !== 1'b0 || addr_bad !== 0) begin
            n_fail++;
            $display("FAIL pattern%0d: got total=%0d ovr=%b bad=%0d expected total=%0d ovr=0 bad=0",
                     p, done_total, done_ovr, addr_bad, tour_len());
         end
      end
   endtask

   task automatic test_random();
      int t, gap;
      bit comb;
      for (int r = 0; r < 8; r++) begin
         shuffle_route();
         gap  = $urandom_range(0, 3);
         comb = 1'($urandom_range(0, 1));
         do_route(gap, comb, t);
         wait_done();
         n_checks++;
         if (done_total !== tour_len() || done_cyc !== t + N + 2 || addr_bad !== 0 || ren_cnt !== N) begin
            n_fail++;
            $display("FAIL random%0d: got total=%0d done@%0d bad=%0d ren=%0d expected total=%0d done@%0d bad=0 ren=%0d",
                     r, done_total, done_cyc, addr_bad, ren_cnt, tour_len(), t + N + 2, N);
         end
      end
   endtask

   task automatic test_gap();
      int t;
      for (int i = 0; i < N; i++) route_c[i] = i;
      do_route(5, 1'b0, t);
      wait_done();
      n_checks++;
      if (done_total !== tour_len() || done_cyc !== t + N + 2) begin
         n_fail++;
         $display("FAIL gap: got total=%0d done@%0d expected total=%0d done@%0d", done_total, done_cyc, tour_len(), t + N + 2);
      end
   endtask

   task automatic test_abort();
      int ta, tb;
      shuffle_route();
      do_route(0, 1'b0, ta);
      repeat (6) begin @(posedge clk); #1; end
      n_checks++;
      if (done_cnt !== 0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL abort_midwalk: got done_cnt=%0d busy=%b expected 0 1", done_cnt, busy);
      end
      shuffle_route();
      do_route(0, 1'b0, tb);
      wait_done();
      repeat (20) @(posedge clk);
      #1;
      n_checks++;
      if (done_cnt !== 1 || done_cyc !== tb + N + 2 || done_total !== tour_len() || done_ovr !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_second: got n=%0d done@%0d total=%0d ovr=%b expected n=1 done@%0d total=%0d ovr=0",
                  done_cnt, done_cyc, done_total, done_ovr, tb + N + 2, tour_len());
      end
   endtask

   task automatic test_overrun();
      int t;
      shuffle_route();
      do_route(0, 1'b0, t);
      repeat (3) begin @(posedge clk); #1; end
      in_valid = 1'b1; in_data = $urandom;
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_done();
      n_checks++;
      if (done_ovr !== 1'b1 || done_total !== tour_len() || done_cyc !== t + N + 2) begin
         n_fail++;
         $display("FAIL overrun: got ovr=%b total=%0d done@%0d expected ovr=1 total=%0d done@%0d",
                  done_ovr, done_total, done_cyc, tour_len(), t + N + 2);
      end
      n_checks++;
      if (overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_sticky: got %b expected 1", overrun); end
   endtask

   task automatic test_reset_mid_walk();
      int t;
      shuffle_route();
      do_route(0, 1'b0, t);
      in_valid = 1'b1; in_data = $urandom;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      n_checks++;
      if (total == '0 || overrun !== 1'b1) begin
         n_fail++;
         $display("FAIL prereset_state: got total=%0d ovr=%b expected nonzero 1", total, overrun);
      end
      reset = 1'b1;
      #1;
      n_checks++;
      if ({busy, done, dist_ren, dist_raddr, total, overrun, perm_error} !== '0) begin
         n_fail++;
         $display("FAIL async_reset: got busy=%b done=%b ren=%b raddr=%h total=%0d ovr=%b perm=%b expected all 0",
                  busy, done, dist_ren, dist_raddr, total, overrun, perm_error);
      end
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      n_checks++;
      if (done_cnt !== 0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_no_done: got done_cnt=%0d busy=%b expected 0 0", done_cnt, busy);
      end
   endtask

   task automatic test_perm();
      int t;
`ifdef ROUTE_DISTANCE_CHECK_EN
      for (int i = 0; i < N; i++) route_c[i] = i;
      route_c[5] = 3;
      do_route(0, 1'b0, t);
      wait_done();
      n_checks++;
      if (done_perm !== 1'b1 || done_total !== tour_len()) begin
         n_fail++;
         $display("FAIL perm_dup: got perm=%b total=%0d expected 1 %0d", done_perm, done_total, tour_len());
      end
`endif
      for (int i = 0; i < N; i++) route_c[i] = i;
      do_route(0, 1'b0, t);
      wait_done();
      n_checks++;
      if (done_perm !== 1'b0 || done_total !== tour_len()) begin
         n_fail++;
         $display("FAIL perm_clean: got perm=%b total=%0d expected 0 %0d", done_perm, done_total, tour_len());
      end
   endtask

   initial begin
      clear_mon();
      test_reset();
      test_identity();
      test_patterns();
      test_random();
      test_gap();
      test_abort();
      test_overrun();
      test_perm();
      test_reset_mid_walk();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/route_distance.md
# route_distance

Downstream consumer of the exchange stage's ordering stream. It captures one full route (`city_div` words of 8 city indices, as emitted on `out_valid`/`out_data`) and walks the closed tour one edge per cycle through an external distance-table read port. It accumulates the total tour length for the replica's energy check. It sits between a replica's exchange output and the replica-exchange energy compare logic.

## Interface
- `city_num`, 16: cities per route; element index ≥ `city_num` in the last word is ignored.
- `city_num_log`, 4: bits per city index.
- `city_div_log`, 1: log2 of words per route; `city_div` = ceil(`city_num`/8) ≤ 2**`city_div_log`.
- `dist_bit`, 8: width of one distance entry.
- `total_bit`, `dist_bit`+`city_num_log`: accumulator width; overflow impossible by construction.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `start`  in  1  begin a new route: clears buffer, counters, `total`, `overrun`, `perm_error`.
- `in_valid`  in  1  ordering word valid; no backpressure.
- `in_data`  in  8*`city_num_log`  8 cities; element [0] is earliest in tour order.
- `dist_raddr`  out  2*`city_num_log`  {from, to} city pair.
- `dist_ren`  out  1  read strobe; data returns exactly 1 cycle later.
- `dist_rdata`  in  `dist_bit`  distance for the previous cycle's `dist_raddr`.
- `busy`  out  1  high from `start` until `done`.
- `done`  out  1  single-cycle pulse; `total` valid this cycle.
- `total`  out  `total_bit`  closed-tour length; held until next `start`/`reset`.
- `overrun`  out  1  sticky: a word arrived while not in LOAD after `start`.
- `perm_error`  out  1  sticky permutation error (see Configuration).

## Operation
- Reset values: all outputs 0; FSM in IDLE.
- FSM states are IDLE, LOAD, WALK, DRAIN, DONE.
- IDLE: `in_valid` words are dropped silently. `start` → LOAD.
- LOAD: each `in_valid` word is written to the word buffer at `wcount` (depth 2**`city_div_log`); `wcount` increments. The cycle the word with `wcount`=`city_div`-1 is written → WALK.
- WALK: a city pointer k = 0..`city_num`-1 issues one read per cycle. The read is `dist_raddr`={c[k], c[k+1]}; for k=`city_num`-1 it is {c[`city_num`-1], c[0]} (tour wrap). After k=`city_num`-1 → DRAIN.
- DRAIN: one cycle to capture the last `dist_rdata` → DONE.
- DONE: `done`=1 for one cycle, `busy` drops → IDLE.
- Accumulation: `total` += `dist_rdata` in the cycle after each `dist_ren`, unsigned, zero-extended.
- `in_valid` during WALK, DRAIN or DONE: word dropped, `overrun` set.
- `start` in any state: aborts the current route and re-enters LOAD with all clears. `start` and `in_valid` in the same cycle: the word is accepted as word 0 of the new route.
- `reset` mid-operation: immediate return to IDLE; no `done` is produced.

## Timing
- The last word is accepted at edge t. The first `dist_ren` is asserted in cycle t+1, and reads are back-to-back for `city_num` cycles (t+1 … t+`city_num`).
- `done` is asserted in cycle t+`city_num`+2.
- Minimum route latency from the first word is `city_div`+`city_num`+2 cycles.
- Words need not be contiguous during LOAD; gaps only delay WALK.
- `dist_ren` is never asserted outside WALK. `dist_raddr` is don't-care when `dist_ren`=0; drive 0.

## Configuration
- `ROUTE_DISTANCE_CHECK_EN` defined:
  - A `city_num`-bit seen-map is cleared on `start` and set per city during LOAD.
  - A duplicate city or index ≥ `city_num` sets `perm_error`, sticky until `start`/`reset`.
  - The total is still computed.
- `ROUTE_DISTANCE_CHECK_EN` undefined: no seen-map logic; `perm_error` is tied to 0.

## Test plan
Default parameters; the distance model returns |from−to|.
- Identity route: `start`, then words {0..7},{8..15} back-to-back → 16 consecutive `dist_ren`, `done` 18 cycles after the second word, `total`=30.
- Reversed route: {15..8},{7..0} → `total`=30. Interleaved route: {0,2,4,…,14},{15,13,…,1} → `total`=30. Both with `overrun`=0.
- Gapped input: word 1 arrives 5 cycles after word 0 → same `total`, `done` 18 cycles after word 1.
- Abort: `start` again mid-WALK, then a new route → no `done` for the first route; the second `total` is correct; `overrun`=0.
- Overrun: an extra word during WALK → `overrun`=1, `total` unaffected. Async `reset` mid-WALK → all outputs 0 the same cycle, no `done`.
- With `ROUTE_DISTANCE_CHECK_EN`: city 3 duplicated in place of city 5 → `perm_error`=1 at `done`. The identity route → `perm_error`=0.
